// File: rtl/mux_2_1.sv
// Purpose : two-input data selector with combinational and registered outputs, plus select-change flag.
// Latency : out is zero-cycle; out_q and sel_chg are one cycle after the sampling edge.
// Backpress: none; the block accepts new inputs every cycle and has no flow control.
module mux_2_1 #(
    parameter int WIDTH = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_chg
);

    // Full-width selected value shared by the output port and the capture register.
    logic [WIDTH-1:0] w_sel_dat;
    // High when the select sampled at this edge differs from the previous sample.
    logic             w_sel_diff;

    // Registered state; the r_ names keep the internal copies distinct from ports.
    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_d;
    logic             r_sel_chg;

    // Plain conditional selection, so X/Z on sel follows simulator semantics.
    always_comb begin
        w_sel_dat = sel ? in1 : in2;
    end

    // Compare the live select against the copy held from the previous edge.
    always_comb begin
        w_sel_diff = (sel != r_sel_d);
    end

    // Capture the selected data every edge; reset clears it immediately.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_out_q <= '0;
        end else begin
            r_out_q <= w_sel_dat;
        end
    end

    // Track the previous select and raise a one-cycle change pulse; reset drops any in-flight pulse.
    // Reset leaves r_sel_d at 0, so a select of 1 at the first edge after release reports a change.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sel_d   <= 1'b0;
            r_sel_chg <= 1'b0;
        end else begin
            r_sel_d   <= sel;
            r_sel_chg <= w_sel_diff;
        end
    end

    assign out     = w_sel_dat;
    assign out_q   = r_out_q;
    assign sel_chg = r_sel_chg;

endmodule

// File: tb/tb_mux_2_1.sv
// Purpose : directed self-checking bench for mux_2_1 at WIDTH=1 and WIDTH=8.
// Latency : checks out at zero cycles, out_q and sel_chg one edge after sampling.
// Backpress: not applicable; stimulus is driven every cycle.
module tb_mux_2_1;

    logic       sys_clk;
    logic       sys_rst;

    logic       in1_1b, in2_1b, sel_1b;
    logic       out_1b, out_q_1b, sel_chg_1b;

    logic [7:0] in1_8b, in2_8b;
    logic       sel_8b;
    logic [7:0] out_8b, out_q_8b;
    logic       sel_chg_8b;

    int n_checks;
    int n_errors;

    mux_2_1 #(.WIDTH(1)) u_dut_1b (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .in1     (in1_1b),
        .in2     (in2_1b),
        .sel     (sel_1b),
        .out     (out_1b),
        .out_q   (out_q_1b),
        .sel_chg (sel_chg_1b)
    );

    mux_2_1 #(.WIDTH(8)) u_dut_8b (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .in1     (in1_8b),
        .in2     (in2_8b),
        .sel     (sel_8b),
        .out     (out_8b),
        .out_q   (out_q_8b),
        .sel_chg (sel_chg_8b)
    );

    // 10 ns clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one full cycle: inputs change at negedge, outputs settle after the posedge.
    task automatic cyc();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Truth table vectors {in1, in2, sel} and expected out.
    logic [2:0] tt_vec [7];
    logic       tt_exp [7];

    initial begin
        n_checks = 0;
        n_errors = 0;

        tt_vec[0] = 3'b000; tt_exp[0] = 1'b0;
        tt_vec[1] = 3'b001; tt_exp[1] = 1'b0;
        tt_vec[2] = 3'b010; tt_exp[2] = 1'b1;
        tt_vec[3] = 3'b011; tt_exp[3] = 1'b0;
        tt_vec[4] = 3'b100; tt_exp[4] = 1'b0;
        tt_vec[5] = 3'b101; tt_exp[5] = 1'b1;
        tt_vec[6] = 3'b111; tt_exp[6] = 1'b1;

        sys_rst = 1'b1;
        in1_1b  = 1'b0; in2_1b = 1'b0; sel_1b = 1'b0;
        in1_8b  = 8'h00; in2_8b = 8'h00; sel_8b = 1'b0;

        // Reset state, including across a clock edge.
        cyc();
        chk("rst_out_q_1b",   out_q_1b,   1'b0);
        chk("rst_sel_chg_1b", sel_chg_1b, 1'b0);
        chk("rst_out_q_8b",   out_q_8b,   8'h00);
        chk("rst_sel_chg_8b", sel_chg_8b, 1'b0);

        // Combinational truth table while reset holds; out must not care about reset.
        for (int i = 0; i < 7; i++) begin
            {in1_1b, in2_1b, sel_1b} = tt_vec[i];
            #100;
            chk($sformatf("tt_out_%0d", i), out_1b, tt_exp[i]);
        end

        // Release reset at a negedge with sel=0.
        @(negedge sys_clk);
        in1_1b = 1'b1; in2_1b = 1'b0; sel_1b = 1'b0;
        sys_rst = 1'b0;
        cyc();
        chk("reg_out_q_sel0", out_q_1b, 1'b0);
        chk("reg_chg_sel0",   sel_chg_1b, 1'b0);

        // Registered path: out flips at once, out_q one edge later, then holds.
        sel_1b = 1'b1;
        #1;
        chk("reg_out_now",      out_1b,   1'b1);
        chk("reg_out_q_before", out_q_1b, 1'b0);
        @(negedge sys_clk);
        cyc();
        chk("reg_out_q_after",  out_q_1b, 1'b1);
        cyc();
        chk("reg_out_q_hold",   out_q_1b, 1'b1);

        // Select-change pulse: return to 0 (pulse), hold 3 cycles (quiet), then 1, then 0.
        sel_1b = 1'b0;
        cyc();
        chk("chg_fall_pulse", sel_chg_1b, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("chg_hold0_%0d", i), sel_chg_1b, 1'b0);
        end
        sel_1b = 1'b1;
        cyc();
        chk("chg_rise_pulse", sel_chg_1b, 1'b1);
        cyc();
        chk("chg_rise_end",   sel_chg_1b, 1'b0);
        sel_1b = 1'b0;
        cyc();
        chk("chg_fall2_pulse", sel_chg_1b, 1'b1);
        cyc();
        chk("chg_fall2_end",   sel_chg_1b, 1'b0);

        // Back-to-back toggles give a continuous pulse.
        for (int i = 0; i < 4; i++) begin
            sel_1b = ~sel_1b;
            cyc();
            chk($sformatf("chg_toggle_%0d", i), sel_chg_1b, 1'b1);
        end
        // sel ends at 0 after four toggles; let it settle.
        cyc();
        chk("chg_toggle_end", sel_chg_1b, 1'b0);

        // Async reset with a pulse in flight and out_q=1.
        sel_1b = 1'b1;
        cyc();
        chk("ar_pre_out_q",   out_q_1b,   1'b1);
        chk("ar_pre_sel_chg", sel_chg_1b, 1'b1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("ar_out_q",   out_q_1b,   1'b0);
        chk("ar_sel_chg", sel_chg_1b, 1'b0);
        chk("ar_out",     out_1b,     1'b1);
        in2_1b = 1'b1; sel_1b = 1'b0;
        #1;
        chk("ar_out_follow", out_1b, 1'b1);
        in2_1b = 1'b0;
        #1;
        chk("ar_out_follow0", out_1b, 1'b0);
        cyc();
        chk("ar_hold_out_q", out_q_1b, 1'b0);
        sel_1b = 1'b1;
        sys_rst = 1'b0;
        cyc();
        chk("ar_rel_sel_chg", sel_chg_1b, 1'b1);
        chk("ar_rel_out_q",   out_q_1b,   1'b1);
        cyc();
        chk("ar_rel_chg_end", sel_chg_1b, 1'b0);

        // Wide data, no bit mixing.
        in1_8b = 8'hA5; in2_8b = 8'h3C; sel_8b = 1'b1;
        #1;
        chk("w8_out_sel1", out_8b, 8'hA5);
        @(negedge sys_clk);
        cyc();
        chk("w8_out_q_sel1", out_q_8b, 8'hA5);
        sel_8b = 1'b0;
        #1;
        chk("w8_out_sel0",      out_8b,   8'h3C);
        chk("w8_out_q_lag",     out_q_8b, 8'hA5);
        @(negedge sys_clk);
        cyc();
        chk("w8_out_q_sel0",    out_q_8b, 8'h3C);
        in1_8b = 8'h0F; in2_8b = 8'hF0; sel_8b = 1'b1;
        #1;
        chk("w8_out_0f", out_8b, 8'h0F);
        @(negedge sys_clk);
        cyc();
        chk("w8_out_q_0f", out_q_8b, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
